// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   pll_state_e    : sequencer states
//   RELOCK_COUNT_W : width of the saturating lock-loss counter
//   timer_width()  : shared timer width from the three cycle parameters
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAILED
  } pll_state_e;

  localparam int unsigned RELOCK_COUNT_W = 8;

  // $clog2 of the largest cycle count plus one bit of headroom.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronized output, SYNC_STAGES cycles of latency
module bit_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock, qualifies lock
// stability, then releases the core reset. Re-sequences on lock loss or on
// request, and latches a failure after repeated lock timeouts.
//   clk          : free-running reference clock
//   rst          : asynchronous active-high reset
//   pll_locked   : PLL lock indicator (asynchronous)
//   force_relock : single-cycle re-sequence request (RUN and FAILED only)
//   pll_rst      : PLL reset, active high
//   sys_reset    : core reset, active high, low only in RUN
//   pll_ok       : high only in RUN
//   failed       : high only in FAILED
//   relock_count : saturating count of lock losses seen in RUN
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pll_locked,
  input  logic                      force_relock,
  output logic                      pll_rst,
  output logic                      sys_reset,
  output logic                      pll_ok,
  output logic                      failed,
  output logic [RELOCK_COUNT_W-1:0] relock_count
);

  localparam int unsigned TIMER_W =
    timer_width(RESET_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  // Timer is cleared on entry, so a phase of N cycles ends when it reads N-1.
  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

  logic                      locked_s;
  pll_state_e                state_q, state_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [RETRY_W-1:0]        retry_q, retry_d;
  logic [RELOCK_COUNT_W-1:0] relock_q, relock_d;

  bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(clk),
    .rst(rst),
    .d  (pll_locked),
    .q  (locked_s)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    unique case (state_q)
      RESET_PLL: begin
        if (timer_q == HOLD_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_q == RETRY_LAST) ? FAILED : RESET_PLL;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        // Lock loss wins over a simultaneous force_relock so it is counted.
        if (!locked_s) begin
          state_d = RESET_PLL;
          if (relock_q != '1) relock_d = relock_q + 1'b1;
        end else if (force_relock) begin
          state_d = RESET_PLL;
        end
      end
      FAILED: begin
        if (force_relock) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    if ((state_d != state_q) || (state_q == RUN) || (state_q == FAILED)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RESET_PLL;
      timer_q  <= '0;
      retry_q  <= '0;
      relock_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      relock_q <= relock_d;
    end
  end

  assign pll_rst      = (state_q == RESET_PLL) || (state_q == FAILED);
  assign sys_reset    = (state_q != RUN);
  assign pll_ok       = (state_q == RUN);
  assign failed       = (state_q == FAILED);
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 20;
  localparam int STABLE  = 8;
  localparam int MAXR    = 2;
  localparam int SYNC    = 2;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_reset;
  logic       pll_ok;
  logic       failed;
  logic [7:0] relock_count;

  int checks;
  int failures;

  pll_reset_sequencer #(
    .RESET_HOLD_CYCLES  (HOLD),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .LOCK_STABLE_CYCLES (STABLE),
    .MAX_RETRIES        (MAXR),
    .SYNC_STAGES        (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .pll_rst     (pll_rst),
    .sys_reset   (sys_reset),
    .pll_ok      (pll_ok),
    .failed      (failed),
    .relock_count(relock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: phases with elapsed-cycle counts, lock seen
  // through a delay line of SYNC samples.
  typedef enum {M_HOLD, M_WAIT, M_QUAL, M_RUN, M_DEAD} mphase_e;
  mphase_e m_phase;
  int      m_elapsed;
  int      m_tries;
  int      m_relock;
  logic    m_pipe[$];

  function automatic void m_reset();
    m_phase   = M_HOLD;
    m_elapsed = 0;
    m_tries   = 0;
    m_relock  = 0;
    m_pipe    = {};
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
  endfunction

  function automatic void m_tick(input logic lk, input logic fr);
    logic    ls;
    mphase_e nxt;
    ls = m_pipe.pop_back();
    m_pipe.push_front(lk);
    m_elapsed++;
    nxt = m_phase;
    case (m_phase)
      M_HOLD: if (m_elapsed == HOLD) nxt = M_WAIT;
      M_WAIT: begin
        if (ls) nxt = M_QUAL;
        else if (m_elapsed == TIMEOUT) begin
          m_tries++;
          nxt = (m_tries == MAXR) ? M_DEAD : M_HOLD;
        end
      end
      M_QUAL: begin
        if (!ls) nxt = M_WAIT;
        else if (m_elapsed == STABLE) begin
          nxt     = M_RUN;
          m_tries = 0;
        end
      end
      M_RUN: begin
        if (!ls) begin
          if (m_relock < 255) m_relock++;
          nxt = M_HOLD;
        end else if (fr) nxt = M_HOLD;
      end
      M_DEAD: begin
        if (fr) begin
          m_tries = 0;
          nxt     = M_HOLD;
        end
      end
      default: nxt = M_HOLD;
    endcase
    if (nxt != m_phase) m_elapsed = 0;
    m_phase = nxt;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic [11:0] act;
    logic [11:0] exp;
    act = {pll_rst, sys_reset, pll_ok, failed, relock_count};
    exp = {(m_phase == M_HOLD) || (m_phase == M_DEAD), m_phase != M_RUN,
           m_phase == M_RUN, m_phase == M_DEAD, 8'(m_relock)};
    chk("model", act, exp);
    if (!sys_reset) chk("sysrst_low_with_pllrst", pll_rst, 0);
  endtask

  // One clock: inputs present at the edge feed the model, outputs sampled #1 later.
  task automatic step();
    logic lk;
    logic fr;
    lk = pll_locked;
    fr = force_relock;
    @(posedge clk);
    if (rst) m_reset();
    else m_tick(lk, fr);
    #1;
    chk_model();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_pll_rst"}, pll_rst, 1);
    chk({nm, "_sys_reset"}, sys_reset, 1);
    chk({nm, "_pll_ok"}, pll_ok, 0);
    chk({nm, "_failed"}, failed, 0);
    chk({nm, "_relock"}, relock_count, 0);
  endtask

  // Asserted mid-cycle; outputs must reach reset values without a clock edge.
  task automatic pulse_rst(input string nm);
    rst = 1'b1;
    #1;
    m_reset();
    chk_reset_outputs(nm);
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic lk;
    logic fr;
    int   n;
    logic e_prst;
    logic e_srst;
    logic e_ok;
    logic e_fail;
    int   e_rc;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic lk, input logic fr, input int n,
                              input logic p, input logic s, input logic o,
                              input logic f, input int rc);
    vec_t v;
    v.lk = lk; v.fr = fr; v.n = n;
    v.e_prst = p; v.e_srst = s; v.e_ok = o; v.e_fail = f; v.e_rc = rc;
    vecs.push_back(v);
  endfunction

  int lk_run;
  logic lk_val;
  int waited;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    pll_locked = 1'b0;
    force_relock = 1'b0;
    m_reset();
    #1;
    chk_reset_outputs("por");
    repeat (2) step();
    chk_reset_outputs("por_clocked");
    rst = 1'b0;

    //   lk fr  n  prst srst ok fail rc
    add(0, 0,  3, 1, 1, 0, 0, 0);  // hold pulse still high
    add(0, 0,  1, 0, 1, 0, 0, 0);  // 4th edge: WAIT_LOCK
    add(0, 1,  1, 0, 1, 0, 0, 0);  // force in WAIT_LOCK ignored
    add(0, 0,  4, 0, 1, 0, 0, 0);
    add(1, 0, 10, 0, 1, 0, 0, 0);  // sync + qualification
    add(1, 0,  1, 0, 0, 1, 0, 0);  // RUN
    add(1, 1,  1, 1, 1, 0, 0, 0);  // force in RUN
    add(1, 0,  4, 0, 1, 0, 0, 0);
    add(1, 0,  1, 0, 1, 0, 0, 0);  // STABLE
    add(1, 0,  7, 0, 1, 0, 0, 0);
    add(1, 0,  1, 0, 0, 1, 0, 0);  // RUN
    add(0, 0,  2, 0, 0, 1, 0, 0);  // loss still in synchronizer
    add(0, 0,  1, 1, 1, 0, 0, 1);  // loss seen
    add(1, 0,  4, 0, 1, 0, 0, 1);
    add(1, 0,  1, 0, 1, 0, 0, 1);
    add(1, 0,  8, 0, 0, 1, 0, 1);  // RUN
    add(0, 0,  2, 0, 0, 1, 0, 1);
    add(0, 1,  1, 1, 1, 0, 0, 2);  // loss + force same cycle: counted once
    add(0, 0,  4, 0, 1, 0, 0, 2);
    add(0, 0, 19, 0, 1, 0, 0, 2);
    add(0, 0,  1, 1, 1, 0, 0, 2);  // first timeout -> retry pulse
    add(0, 0,  3, 1, 1, 0, 0, 2);
    add(0, 0,  1, 0, 1, 0, 0, 2);
    add(0, 0, 19, 0, 1, 0, 0, 2);
    add(0, 0,  1, 1, 1, 0, 1, 2);  // second timeout -> FAILED
    add(0, 0,  5, 1, 1, 0, 1, 2);
    add(0, 1,  1, 1, 1, 0, 0, 2);  // force leaves FAILED
    add(0, 0,  4, 0, 1, 0, 0, 2);

    foreach (vecs[i]) begin
      pll_locked = vecs[i].lk;
      force_relock = vecs[i].fr;
      repeat (vecs[i].n) step();
      chk($sformatf("vec%0d_pll_rst", i), pll_rst, vecs[i].e_prst);
      chk($sformatf("vec%0d_sys_reset", i), sys_reset, vecs[i].e_srst);
      chk($sformatf("vec%0d_pll_ok", i), pll_ok, vecs[i].e_ok);
      chk($sformatf("vec%0d_failed", i), failed, vecs[i].e_fail);
      chk($sformatf("vec%0d_relock", i), relock_count, vecs[i].e_rc);
    end
    force_relock = 1'b0;

    // Glitchy lock: one low sample restarts qualification.
    pll_locked = 1'b0;
    pulse_rst("glitch_rst");
    repeat (4) step();
    chk("glitch_wait_pll_rst", pll_rst, 0);
    for (int i = 1; i <= 16; i++) begin
      pll_locked = (i == 6) ? 1'b0 : 1'b1;
      step();
      chk($sformatf("glitch_hold_%0d", i), sys_reset, 1);
      chk($sformatf("glitch_pllrst_%0d", i), pll_rst, 0);
    end
    step();
    chk("glitch_release", sys_reset, 0);
    chk("glitch_relock", relock_count, 0);

    // Repeated loss in RUN: counter saturates.
    for (int k = 1; k <= 300; k++) begin
      pll_locked = 1'b0;
      repeat (2) step();
      chk("loss_sync_latency", sys_reset, 0);
      step();
      chk("loss_pll_rst", pll_rst, 1);
      chk("loss_sys_reset", sys_reset, 1);
      chk("loss_count", relock_count, (k < 255) ? k : 255);
      pll_locked = 1'b1;
      waited = 0;
      while (!pll_ok && waited < 40) begin
        step();
        waited++;
      end
      chk("relock_cycles", waited, 13);
    end

    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    chk("force_run_pll_rst", pll_rst, 1);
    chk("force_run_count", relock_count, 255);

    // Async reset in the middle of STABLE.
    repeat (8) step();
    chk("mid_stable_sys_reset", sys_reset, 1);
    pulse_rst("mid_stable_rst");
    repeat (12) step();
    chk("restart_hold", sys_reset, 1);
    step();
    chk("restart_release", sys_reset, 0);
    chk("restart_ok", pll_ok, 1);

    // Randomized lock behaviour and requests against the reference.
    lk_run = 0;
    lk_val = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (lk_run == 0) begin
        lk_val = ($urandom_range(0, 3) != 0);
        lk_run = lk_val ? $urandom_range(1, 40) : $urandom_range(1, 60);
      end
      lk_run--;
      pll_locked = lk_val;
      force_relock = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 999) == 0) pulse_rst("rand_rst");
      else step();
    end
    force_relock = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
